// File: rtl/array_mem_arbiter_if.sv
// Two-port request/response bundle for array_mem_arbiter.
// Per port p in {0,1}:
//   req_p, we_p, addr_p, wdata_p : requester -> arbiter
//   gnt_p (combinational), rvalid_p, rdata_p, err_p : arbiter -> requester
// master: requester side, slave: arbiter side.
interface array_mem_arbiter_if #(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
);
    localparam int unsigned AW = ($clog2(WA) < 1) ? 1 : $clog2(WA);

    logic          req_0;
    logic          we_0;
    logic [AW-1:0] addr_0;
    logic [WB-1:0] wdata_0;
    logic          gnt_0;
    logic          rvalid_0;
    logic [WB-1:0] rdata_0;
    logic          err_0;

    logic          req_1;
    logic          we_1;
    logic [AW-1:0] addr_1;
    logic [WB-1:0] wdata_1;
    logic          gnt_1;
    logic          rvalid_1;
    logic [WB-1:0] rdata_1;
    logic          err_1;

    modport master (
        output req_0, we_0, addr_0, wdata_0,
        input  gnt_0, rvalid_0, rdata_0, err_0,
        output req_1, we_1, addr_1, wdata_1,
        input  gnt_1, rvalid_1, rdata_1, err_1
    );

    modport slave (
        input  req_0, we_0, addr_0, wdata_0,
        output gnt_0, rvalid_0, rdata_0, err_0,
        input  req_1, we_1, addr_1, wdata_1,
        output gnt_1, rvalid_1, rdata_1, err_1
    );
endinterface

// File: rtl/array_mem_arbiter.sv
// Owner of a single-port WA x WB array shared by two requesters.
// After reset an init sequencer writes mem[a] = a over WA cycles, then the
// array is served with round-robin arbitration and one-cycle read latency.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   busy  : registered, high while the init sequencer runs
//   bus   : two-port request/response bundle (slave side)
module array_mem_arbiter #(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                busy,
    array_mem_arbiter_if.slave  bus
);
    localparam int unsigned     AW        = ($clog2(WA) < 1) ? 1 : $clog2(WA);
    localparam logic [0:0]      ST_INIT   = 1'b0;
    localparam logic [0:0]      ST_RUN    = 1'b1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(WA - 1);
    localparam logic [AW:0]     WA_W      = (AW+1)'(WA);

    logic [WB-1:0] mem [WA-1:0];

    logic [0:0]    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          prio, prio_nxt;
    logic          gnt_0_c, gnt_1_c;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [WB-1:0] acc_wdata;
    logic          acc_in_range;

    // State, init counter and priority pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            prio  <= 1'b0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prio  <= prio_nxt;
            busy  <= (state_nxt == ST_INIT);
        end
    end

    // Next state, grants and the muxed access of the granted port
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prio_nxt  = prio;
        gnt_0_c   = 1'b0;
        gnt_1_c   = 1'b0;

        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (bus.req_0 && (!bus.req_1 || !prio)) begin
                    gnt_0_c = 1'b1;
                end else if (bus.req_1) begin
                    gnt_1_c = 1'b1;
                end
                // Pointer moves to the loser; with no grant it holds
                if (gnt_0_c) prio_nxt = 1'b1;
                if (gnt_1_c) prio_nxt = 1'b0;
            end
        endcase

        acc_we       = gnt_1_c ? bus.we_1    : bus.we_0;
        acc_addr     = gnt_1_c ? bus.addr_1  : bus.addr_0;
        acc_wdata    = gnt_1_c ? bus.wdata_1 : bus.wdata_0;
        acc_in_range = ({1'b0, acc_addr} < WA_W);
    end

    assign bus.gnt_0 = gnt_0_c;
    assign bus.gnt_1 = gnt_1_c;

    // Array writes: init fill, then in-range granted writes; none during reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[cnt] <= WB'(cnt);
            end else if ((gnt_0_c || gnt_1_c) && acc_we && acc_in_range) begin
                mem[acc_addr] <= acc_wdata;
            end
        end
    end

    // Per-port responses; out-of-range reads return zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rvalid_0 <= 1'b0;
            bus.err_0    <= 1'b0;
            bus.rdata_0  <= '0;
            bus.rvalid_1 <= 1'b0;
            bus.err_1    <= 1'b0;
            bus.rdata_1  <= '0;
        end else begin
            bus.rvalid_0 <= gnt_0_c && !acc_we;
            bus.err_0    <= gnt_0_c && !acc_in_range;
            bus.rvalid_1 <= gnt_1_c && !acc_we;
            bus.err_1    <= gnt_1_c && !acc_in_range;
            if (gnt_0_c && !acc_we) begin
                bus.rdata_0 <= acc_in_range ? mem[acc_addr] : '0;
            end
            if (gnt_1_c && !acc_we) begin
                bus.rdata_1 <= acc_in_range ? mem[acc_addr] : '0;
            end
        end
    end
endmodule

// File: tb/tb_array_mem_arbiter.sv
// Self-checking bench for array_mem_arbiter.
// Main instance WA=6/WB=8 (non power of two, out-of-range addresses 6 and 7)
// is checked against a behavioural model every cycle, plus a vector table and
// hand sequences. Two width variants check init truncation/extension.
module tb_array_mem_arbiter;
    localparam int WA = 6;

    logic clk;
    logic rst_n;
    logic rst_n_v;
    logic busy;
    logic busy16;
    logic busy4;

    int n_checks;
    int n_err;

    array_mem_arbiter_if #(.WA(6),  .WB(8))  bus ();
    array_mem_arbiter_if #(.WA(16), .WB(3))  bus16 ();
    array_mem_arbiter_if #(.WA(4),  .WB(12)) bus4 ();

    array_mem_arbiter #(.WA(6), .WB(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .busy  (busy),
        .bus   (bus)
    );

    array_mem_arbiter #(.WA(16), .WB(3)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n_v),
        .busy  (busy16),
        .bus   (bus16)
    );

    array_mem_arbiter #(.WA(4), .WB(12)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n_v),
        .busy  (busy4),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: array contents, init countdown, priority, responses
    logic [7:0] mref [WA];
    int         init_left = WA;
    int         m_prio;
    logic       m_busy;
    logic       m_rv [2];
    logic [7:0] m_rd [2];
    logic       m_err [2];
    logic       armed = 1'b0;
    logic       last_g0;
    logic       last_g1;

    typedef struct {
        int         req0, we0, a0, d0, req1, we1, a1, d1;
        logic       g0, g1;
        logic       rv0;
        logic [7:0] rd0;
        logic       e0;
        logic       rv1;
        logic [7:0] rd1;
        logic       e1;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle on the main instance, checked against the model
    task automatic step(input int rst, input int r0, input int w0, input int a0, input int d0,
                        input int r1, input int w1, input int a1, input int d1);
        logic eg0, eg1;
        int   p, a, d, we;
        @(negedge clk);
        rst_n       = (rst != 0);
        bus.req_0   = (r0 != 0);
        bus.we_0    = (w0 != 0);
        bus.addr_0  = 3'(a0);
        bus.wdata_0 = 8'(d0);
        bus.req_1   = (r1 != 0);
        bus.we_1    = (w1 != 0);
        bus.addr_1  = 3'(a1);
        bus.wdata_1 = 8'(d1);
        #1;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (init_left == 0) begin
            if (r0 != 0 && (r1 == 0 || m_prio == 0)) eg0 = 1'b1;
            else if (r1 != 0)                        eg1 = 1'b1;
        end
        last_g0 = bus.gnt_0;
        last_g1 = bus.gnt_1;
        if (armed) begin
            chk("gnt_0", 32'(bus.gnt_0), 32'(eg0));
            chk("gnt_1", 32'(bus.gnt_1), 32'(eg1));
        end
        @(posedge clk);
        if (rst == 0) begin
            armed     = 1'b1;
            init_left = WA;
            m_prio    = 0;
            m_busy    = 1'b1;
            for (int i = 0; i < WA; i++) mref[i] = 8'(i);
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0; m_err[i] = 1'b0; m_rd[i] = 8'h00;
            end
        end else if (init_left > 0) begin
            init_left--;
            m_busy = (init_left > 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0; m_err[i] = 1'b0;
            end
            if (eg0 || eg1) begin
                p  = eg0 ? 0 : 1;
                a  = eg0 ? (a0 % 8) : (a1 % 8);
                d  = eg0 ? d0 : d1;
                we = eg0 ? w0 : w1;
                if (we != 0) begin
                    if (a < WA) mref[a] = 8'(d);
                end else begin
                    m_rv[p] = 1'b1;
                    m_rd[p] = (a < WA) ? mref[a] : 8'h00;
                end
                m_err[p] = (a >= WA);
                m_prio   = 1 - p;
            end
        end
        #1;
        if (armed) begin
            chk("busy",     32'(busy),         32'(m_busy));
            chk("rvalid_0", 32'(bus.rvalid_0), 32'(m_rv[0]));
            chk("rdata_0",  32'(bus.rdata_0),  32'(m_rd[0]));
            chk("err_0",    32'(bus.err_0),    32'(m_err[0]));
            chk("rvalid_1", 32'(bus.rvalid_1), 32'(m_rv[1]));
            chk("rdata_1",  32'(bus.rdata_1),  32'(m_rd[1]));
            chk("err_1",    32'(bus.err_1),    32'(m_err[1]));
        end
    endtask

    task automatic idle(input int rst);
        step(rst, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rst_n_v  = 1'b0;
        bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
        bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;
        bus16.req_0 = 1'b0; bus16.we_0 = 1'b0; bus16.addr_0 = '0; bus16.wdata_0 = '0;
        bus16.req_1 = 1'b0; bus16.we_1 = 1'b0; bus16.addr_1 = '0; bus16.wdata_1 = '0;
        bus4.req_0 = 1'b0; bus4.we_0 = 1'b0; bus4.addr_0 = '0; bus4.wdata_0 = '0;
        bus4.req_1 = 1'b0; bus4.we_1 = 1'b0; bus4.addr_1 = '0; bus4.wdata_1 = '0;

        //                req we a  d     req we a  d    g0    g1    rv0   rd0    e0    rv1   rd1    e1
        vt[0]  = '{1, 0, 5, 0,    0, 0, 0, 0,    1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1, 0, 1, 0,    1, 0, 2, 0,    1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h02, 1'b0};
        vt[2]  = '{1, 0, 4, 0,    1, 0, 0, 0,    1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 8'h02, 1'b0};
        vt[3]  = '{0, 0, 0, 0,    1, 1, 3, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h02, 1'b0};
        vt[4]  = '{1, 0, 3, 0,    0, 0, 0, 0,    1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h02, 1'b0};
        vt[5]  = '{1, 0, 2, 0,    0, 0, 0, 0,    1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0};
        vt[6]  = '{0, 0, 0, 0,    1, 1, 7, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h02, 1'b1};
        vt[7]  = '{0, 0, 0, 0,    1, 0, 7, 0,    1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 8'h00, 1'b1};
        vt[8]  = '{1, 0, 6, 0,    0, 0, 0, 0,    1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[9]  = '{0, 0, 0, 0,    0, 0, 0, 0,    1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[10] = '{1, 1, 0, 8'h3C, 1, 1, 0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[11] = '{1, 0, 0, 0,    1, 0, 1, 0,    1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0};

        // Reset held two cycles, then init with both ports requesting
        idle(0);
        idle(0);
        for (int i = 0; i < WA; i++) begin
            step(1, 1, 0, 1, 0, 1, 0, 2, 0);
            chk("init_gnt_0", 32'(last_g0), 32'(0));
            chk("init_gnt_1", 32'(last_g1), 32'(0));
            chk("init_busy",  32'(busy),    32'(i < WA - 1));
        end

        // Contention: grants alternate starting at port 0
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 0, k, 0, 1, 0, 5 - k, 0);
            chk("cont_gnt_0",    32'(last_g0),      32'(k % 2 == 0));
            chk("cont_gnt_1",    32'(last_g1),      32'(k % 2 == 1));
            chk("cont_rvalid_0", 32'(bus.rvalid_0), 32'(k % 2 == 0));
            chk("cont_rvalid_1", 32'(bus.rvalid_1), 32'(k % 2 == 1));
        end

        // Read after init, then sweep the whole array
        step(1, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("init_rvalid", 32'(bus.rvalid_0), 32'(1));
        chk("init_rd5",    32'(bus.rdata_0),  32'(5));
        for (int a = 0; a < WA; a++) begin
            step(1, 1, 0, a, 0, 0, 0, 0, 0);
            chk("sweep_init", 32'(bus.rdata_0), 32'(a));
        end

        // Vector table
        for (int i = 0; i < 12; i++) begin
            step(1, vt[i].req0, vt[i].we0, vt[i].a0, vt[i].d0,
                    vt[i].req1, vt[i].we1, vt[i].a1, vt[i].d1);
            chk("vec_gnt_0",    32'(last_g0),      32'(vt[i].g0));
            chk("vec_gnt_1",    32'(last_g1),      32'(vt[i].g1));
            chk("vec_rvalid_0", 32'(bus.rvalid_0), 32'(vt[i].rv0));
            chk("vec_rdata_0",  32'(bus.rdata_0),  32'(vt[i].rd0));
            chk("vec_err_0",    32'(bus.err_0),    32'(vt[i].e0));
            chk("vec_rvalid_1", 32'(bus.rvalid_1), 32'(vt[i].rv1));
            chk("vec_rdata_1",  32'(bus.rdata_1),  32'(vt[i].rd1));
            chk("vec_err_1",    32'(bus.err_1),    32'(vt[i].e1));
        end

        // Array after the table: only addr 0 and 3 were changed
        for (int a = 0; a < WA; a++) begin
            step(1, 0, 0, 0, 0, 1, 0, a, 0);
            chk("sweep_post", 32'(bus.rdata_1),
                32'((a == 0) ? 8'h77 : (a == 3) ? 8'hA5 : 8'(a)));
        end

        // Reset during a granted read: response discarded, array reinitialised
        step(0, 1, 0, 3, 0, 0, 0, 0, 0);
        chk("rst_rvalid", 32'(bus.rvalid_0), 32'(0));
        chk("rst_busy",   32'(busy),         32'(1));
        for (int i = 0; i < WA; i++) begin
            idle(1);
            chk("rst_busy_run", 32'(busy), 32'(i < WA - 1));
        end
        step(1, 1, 0, 3, 0, 0, 0, 0, 0);
        chk("rst_rd3", 32'(bus.rdata_0), 32'(3));

        // Reset again at init cycle 4: init must restart from address 0
        step(1, 0, 0, 0, 0, 1, 1, 5, 8'hEE);
        step(1, 0, 0, 0, 0, 1, 1, 0, 8'hDD);
        idle(0);
        for (int i = 0; i < 4; i++) idle(1);
        idle(0);
        for (int i = 0; i < WA; i++) begin
            idle(1);
            chk("reinit_busy", 32'(busy), 32'(i < WA - 1));
        end
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("reinit_rd0", 32'(bus.rdata_0), 32'(0));
        step(1, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("reinit_rd5", 32'(bus.rdata_0), 32'(5));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end

        // Width variants: WB=3 truncates, WB=12 zero-extends
        @(negedge clk);
        rst_n_v = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        chk("w16_busy", 32'(busy16), 32'(0));
        chk("w4_busy",  32'(busy4),  32'(0));
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            bus16.req_0  = 1'b1;
            bus16.addr_0 = 4'(a);
            bus4.req_0   = 1'b1;
            bus4.addr_0  = 2'(a);
            @(posedge clk);
            #1;
            chk("w16_rvalid", 32'(bus16.rvalid_0), 32'(1));
            chk("w16_rdata",  32'(bus16.rdata_0),  32'(a % 8));
            chk("w4_rvalid",  32'(bus4.rvalid_0),  32'(1));
            chk("w4_rdata",   32'(bus4.rdata_0),   32'(a % 4));
        end
        @(negedge clk);
        bus16.req_0 = 1'b0;
        bus4.req_0  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
